// File: rtl/audio_dac_tx.sv
// ---------------------------------------------------------------------------
// audio_dac_tx -- I2S master transmitter for the codec DAC.
//
// Serializes one stereo pair per frame onto AUD_DACDAT (MSB first, one BCLK
// of delay after each AUD_DACLRCK edge). AUD_BCLK and AUD_DACLRCK are
// generated here from clk. Upstream hands samples in through a valid/ready
// handshake into a single stereo holding register. That register is drained
// into the shift words at every frame boundary.
//
// Parameters
//   WIDTH          sample width in bits (WIDTH <= SLOT_BITS-1)
//   SLOT_BITS      BCLK periods per channel slot (frame = 2*SLOT_BITS)
//   BCLK_HALF_DIV  clk cycles per BCLK half period (>= 2)
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   left_in, right_in     signed stereo sample
//   in_valid / in_ready   sample handshake (transfer on valid && ready)
//   AUD_BCLK              bit clock to codec
//   AUD_DACLRCK           0 = left slot, 1 = right slot
//   AUD_DACDAT            serial data, changes on BCLK falling edge
//   frame_start           one-clk pulse when a frame is loaded
//   underrun              one-clk pulse when a frame loads with no sample
//
// Optional feature (macro AUDIO_DAC_TX_UNDERRUN_HOLD_EN)
//   When defined, an underrun frame repeats the last transmitted pair
//   instead of sending silence. underrun still pulses.
// ---------------------------------------------------------------------------
module audio_dac_tx #(
    parameter int WIDTH         = 16,
    parameter int SLOT_BITS     = 32,
    parameter int BCLK_HALF_DIV = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] left_in,
    input  logic signed [WIDTH-1:0] right_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    AUD_BCLK,
    output logic                    AUD_DACLRCK,
    output logic                    AUD_DACDAT,
    output logic                    frame_start,
    output logic                    underrun
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(BCLK_HALF_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_N   = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] WIDTH_N  = BIT_W'(WIDTH);

    // Stereo pair as moved between the holding register and shift words.
    typedef struct packed {
        logic [WIDTH-1:0] right;
        logic [WIDTH-1:0] left;
    } pair_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [1:0][WIDTH-1:0] shift_word;   // [0] = left, [1] = right
    pair_t                 hold_q;
    logic                  hold_full;
    pair_t                 last_q;       // last pair loaded from the holding register

    // ---------------------------------------------------------------------
    // Next-state signals
    // ---------------------------------------------------------------------
    logic [DIV_W-1:0]      div_cnt_nxt;
    logic                  bclk_nxt;
    logic [BIT_W-1:0]      bit_cnt_nxt;
    logic                  lrck_nxt;
    logic                  dat_nxt;
    logic                  frame_start_nxt;
    logic                  underrun_nxt;
    logic [1:0][WIDTH-1:0] shift_word_nxt;
    pair_t                 hold_nxt;
    logic                  hold_full_nxt;
    pair_t                 last_nxt;

    // Decoded events and slot position
    logic             bclk_tick;
    logic             bclk_fall;
    logic             frame_load;
    logic             accept;
    logic [BIT_W-1:0] bit_inc;
    logic             chan;
    logic [BIT_W-1:0] pos;
    logic             data_phase;
    pair_t            fill_pair;

    assign in_ready = ~hold_full;
    assign accept   = in_valid & in_ready;

    // The divider terminal count toggles BCLK; every serial output moves only
    // on the toggle that takes BCLK from 1 to 0.
    assign bclk_tick  = (div_cnt == DIV_TC);
    assign bclk_fall  = bclk_tick & AUD_BCLK;
    assign frame_load = bclk_fall & (bit_cnt == BIT_LAST);

    // Position of the bit about to be driven. The slot's first bit period
    // is the I2S delay bit, so sample bits occupy positions 1..WIDTH.
    assign bit_inc    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    assign chan       = (bit_inc >= SLOT_N);
    assign pos        = chan ? (bit_inc - SLOT_N) : bit_inc;
    assign data_phase = (pos != '0) && (pos <= WIDTH_N);

    // What an empty holding register turns into at a frame load.
`ifdef AUDIO_DAC_TX_UNDERRUN_HOLD_EN
    assign fill_pair = last_q;
`else
    assign fill_pair = '0;
`endif

    always_comb begin
        div_cnt_nxt     = div_cnt + 1'b1;
        bclk_nxt        = AUD_BCLK;
        bit_cnt_nxt     = bit_cnt;
        lrck_nxt        = AUD_DACLRCK;
        dat_nxt         = AUD_DACDAT;
        frame_start_nxt = 1'b0;
        underrun_nxt    = 1'b0;
        shift_word_nxt  = shift_word;
        hold_nxt        = hold_q;
        hold_full_nxt   = hold_full;
        last_nxt        = last_q;

        if (bclk_tick) begin
            div_cnt_nxt = '0;
            bclk_nxt    = ~AUD_BCLK;
        end

        if (bclk_fall) begin
            bit_cnt_nxt = bit_inc;
            lrck_nxt    = chan;
            // The shift word MSB is the bit for this position; the word is
            // consumed one bit per falling edge of its own slot.
            dat_nxt     = data_phase ? shift_word[chan][WIDTH-1] : 1'b0;
            if (data_phase)
                shift_word_nxt[chan] = shift_word[chan] << 1;
        end

        // Frame load overrides the shift above: position 0 emits the delay
        // bit, so the fresh words are not touched this edge.
        if (frame_load) begin
            frame_start_nxt = 1'b1;
            if (hold_full) begin
                shift_word_nxt[0] = hold_q.left;
                shift_word_nxt[1] = hold_q.right;
                last_nxt          = hold_q;
                hold_full_nxt     = 1'b0;
            end else begin
                shift_word_nxt[0] = fill_pair.left;
                shift_word_nxt[1] = fill_pair.right;
                underrun_nxt      = 1'b1;
            end
        end

        // accept implies the register was empty, so it never collides with
        // the drain above; an accept on an underrun load waits a frame.
        if (accept) begin
            hold_nxt.left  = left_in;
            hold_nxt.right = right_in;
            hold_full_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            AUD_BCLK    <= 1'b0;
            bit_cnt     <= BIT_LAST;
            AUD_DACLRCK <= 1'b1;
            AUD_DACDAT  <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            shift_word  <= '0;
            hold_q      <= '0;
            hold_full   <= 1'b0;
            last_q      <= '0;
        end else begin
            div_cnt     <= div_cnt_nxt;
            AUD_BCLK    <= bclk_nxt;
            bit_cnt     <= bit_cnt_nxt;
            AUD_DACLRCK <= lrck_nxt;
            AUD_DACDAT  <= dat_nxt;
            frame_start <= frame_start_nxt;
            underrun    <= underrun_nxt;
            shift_word  <= shift_word_nxt;
            hold_q      <= hold_nxt;
            hold_full   <= hold_full_nxt;
            last_q      <= last_nxt;
        end
    end

endmodule
